// File: rtl/montgomery_mult.sv
// Bit-serial radix-2 Montgomery multiplier: o_dout = a*b*2^(-WIDTH) mod m, one multiplier bit per clock.
// Define MONT_FINAL_SUB_EN to include the CORR state that fully reduces the result into [0, m-1].
module montgomery_mult #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_done,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef MONT_FINAL_SUB_EN
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_CORR, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH+1:0] r_u;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;

    logic             w_last;
    logic [WIDTH+1:0] w_t;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH+1:0] w_u_next;

    // u stays below 2^(WIDTH+1), so u + b + m never exceeds WIDTH+2 bits.
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_t      = r_u + ({(WIDTH+2){r_a[r_cnt]}} & {2'b00, r_b});
    assign w_sum    = w_t + ({(WIDTH+2){w_t[0]}} & {2'b00, r_m});
    assign w_u_next = w_sum >> 1;

`ifdef MONT_FINAL_SUB_EN
    logic             w_ge;
    logic [WIDTH+1:0] w_diff;
    assign w_ge   = (r_u >= {2'b00, r_m});
    assign w_diff = r_u - {2'b00, r_m};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_next = ST_CALC;
`ifdef MONT_FINAL_SUB_EN
            ST_CALC: if (w_last) w_state_next = ST_CORR;
            ST_CORR: w_state_next = ST_DONE;
`else
            ST_CALC: if (w_last) w_state_next = ST_DONE;
`endif
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: every register here uses <= so all of them see the pre-edge values of r_u and r_cnt.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_m    <= '0;
            r_u    <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_m   <= i_m;
                        r_u   <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_CALC: begin
                    r_u   <= w_u_next;
                    r_cnt <= r_cnt + 1'b1;
`ifndef MONT_FINAL_SUB_EN
                    if (w_last) r_dout <= w_u_next[WIDTH-1:0];
`endif
                end
`ifdef MONT_FINAL_SUB_EN
                ST_CORR: r_dout <= w_ge ? w_diff[WIDTH-1:0] : r_u[WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    assign o_dout = r_dout;
    assign o_done = (r_state == ST_DONE);
    assign o_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_montgomery_mult.sv
// Directed bench for montgomery_mult (WIDTH=4); expected results and latency follow MONT_FINAL_SUB_EN.
module tb_montgomery_mult;

    localparam int W = 4;
`ifdef MONT_FINAL_SUB_EN
    localparam int LAT = W + 2;
    localparam logic [3:0] EXP_M11 = 4'd3;
`else
    localparam int LAT = W + 1;
    localparam logic [3:0] EXP_M11 = 4'd14;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic [W-1:0] i_m = '0;
    logic [W-1:0] o_dout;
    logic         o_done;
    logic         o_busy;

    int total = 0;
    int bad   = 0;

    montgomery_mult #(.WIDTH(W)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_m    (i_m),
        .o_dout (o_dout),
        .o_done (o_done),
        .o_busy (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: plain, 1: scramble inputs while busy, 2: extra start pulse mid-CALC,
    // 3: plain but o_dout must read 0 until done (follows a reset).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] m,
                          input logic [3:0] exp, input string tag, input int mode);
        int c, done_at, busy_n, dout_bad, extra_done, extra_busy;
        i_a = a; i_b = b; i_m = m; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        c = 1; done_at = 0; busy_n = 0; dout_bad = 0;
        while (done_at == 0 && c <= 30) begin
            if (o_busy) busy_n++;
            if (o_done) done_at = c;
            else begin
                if (mode == 3 && o_dout !== 4'd0) dout_bad++;
                if (mode == 1) begin
                    i_a = 4'($urandom);
                    i_b = 4'($urandom);
                    i_m = 4'($urandom);
                end
                if (mode == 2) begin
                    i_start = (c == 2);
                    i_a = 4'd12; i_b = 4'd12; i_m = 4'd11;
                end
                tick();
                c++;
            end
        end
        i_start = 1'b0;
        check({tag, "_latency"}, done_at, LAT);
        check({tag, "_busy_cycles"}, busy_n, LAT - 1);
        check({tag, "_dout"}, o_dout, exp);
        if (mode == 3) check({tag, "_dout_zero_before_done"}, dout_bad, 0);
        extra_done = 0; extra_busy = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_done) extra_done++;
            if (o_busy) extra_busy++;
        end
        check({tag, "_no_extra_done"}, extra_done, 0);
        check({tag, "_idle_after"}, extra_busy, 0);
        check({tag, "_dout_held"}, o_dout, exp);
    endtask

    initial begin
        int late_done;
        i_rst = 1'b1;
        tick();
        tick();
        check("reset_dout", o_dout, 0);
        check("reset_done", o_done, 0);
        check("reset_busy", o_busy, 0);
        i_rst = 1'b0;
        tick();

        run_op(4'd1,  4'd1,  4'd13, 4'd9,    "one_one_m13",   0);
        run_op(4'd5,  4'd7,  4'd13, 4'd3,    "a5_b7_m13",     0);
        run_op(4'd12, 4'd12, 4'd13, 4'd9,    "a12_b12_m13",   0);
        run_op(4'd7,  4'd10, 4'd11, EXP_M11, "a7_b10_m11",    0);
        run_op(4'd0,  4'd9,  4'd13, 4'd0,    "a0_b9_m13",     0);
        run_op(4'd5,  4'd7,  4'd13, 4'd3,    "scramble_m13",  1);
        run_op(4'd1,  4'd1,  4'd13, 4'd9,    "restart_ign",   2);

        // Reset in the third CALC cycle drops the operation.
        i_a = 4'd12; i_b = 4'd12; i_m = 4'd13; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_dout", o_dout, 0);
        check("midrst_done", o_done, 0);
        check("midrst_busy", o_busy, 0);
        run_op(4'd5, 4'd7, 4'd13, 4'd3, "after_rst", 3);

        // Reset and start on the same edge: reset wins, nothing is started.
        i_a = 4'd5; i_b = 4'd7; i_m = 4'd13; i_rst = 1'b1; i_start = 1'b1;
        tick();
        i_rst = 1'b0; i_start = 1'b0;
        check("rst_start_busy", o_busy, 0);
        check("rst_start_dout", o_dout, 0);
        late_done = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_done) late_done++;
        end
        check("rst_start_no_done", late_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
